// File: rtl/d_latch.sv
// rtl/d_latch.sv - WIDTH-bit level-sensitive D latch, transparent while clk is high
module d_latch #(
  parameter int unsigned      WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Storage is a genuine latch on purpose: q is open while clk=1 and frozen while clk=0.
  // Reset only has effect while the latch is open, and it wins over d. No power-up
  // value is assigned, so q stays X until the first clk=1 interval.
  always_latch begin
    if (clk) begin
      if (rst) begin
        q <= RST_VAL;
      end else begin
        q <= d;
      end
    end
  end

endmodule

// File: tb/tb_d_latch.sv
// tb/tb_d_latch.sv - directed self-checking bench for d_latch
module tb_d_latch;

  logic       clk;
  logic       rst;
  logic       d1;
  logic [7:0] d8;
  logic       q1;
  logic [7:0] q8;
  logic [7:0] q8r;

  int total = 0;
  int bad   = 0;

  d_latch #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .d(d1), .q(q1)
  );

  d_latch #(.WIDTH(8), .RST_VAL(8'h00)) u_w8 (
    .clk(clk), .rst(rst), .d(d8), .q(q8)
  );

  d_latch #(.WIDTH(8), .RST_VAL(8'h3C)) u_w8r (
    .clk(clk), .rst(rst), .d(d8), .q(q8r)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] gexp;
    clk = 1'b0;
    rst = 1'b0;
    d1  = 1'b0;
    d8  = 8'h00;

    // hold: clk low from power-up, q must stay X
    #1; chk("hold_init_w1", {7'b0, q1}, {7'b0, 1'bx});
    chk("hold_init_w8", q8, 8'hxx);
    rst = 1'b1;
    #1; chk("hold_rst_w1", {7'b0, q1}, {7'b0, 1'bx});
    chk("hold_rst_w8r", q8r, 8'hxx);
    rst = 1'b0;
    d1 = 1'b1; d8 = 8'hFF;
    #1; chk("hold_d1_w1", {7'b0, q1}, {7'b0, 1'bx});
    chk("hold_d1_w8", q8, 8'hxx);
    d1 = 1'b0; d8 = 8'h00;
    #1; chk("hold_d0_w1", {7'b0, q1}, {7'b0, 1'bx});

    // transparency
    clk = 1'b1; d1 = 1'b1; d8 = 8'hA5;
    #1; chk("transp_w1_1", {7'b0, q1}, 8'h01);
    chk("transp_w8", q8, 8'hA5);
    chk("transp_w8r", q8r, 8'hA5);
    d1 = 1'b0;
    #1; chk("transp_w1_0", {7'b0, q1}, 8'h00);

    // capture at falling edge
    d1 = 1'b1; d8 = 8'h5A;
    #1; clk = 1'b0;
    #1; d1 = 1'b0; d8 = 8'h00;
    #1; chk("capture_hold_w1", {7'b0, q1}, 8'h01);
    chk("capture_hold_w8", q8, 8'h5A);
    clk = 1'b1;
    #1; chk("capture_reopen_w1", {7'b0, q1}, 8'h00);
    chk("capture_reopen_w8", q8, 8'h00);

    // reset priority while open
    d1 = 1'b1; d8 = 8'hC3; rst = 1'b1;
    #1; chk("rstpri_w1", {7'b0, q1}, 8'h00);
    chk("rstpri_w8", q8, 8'h00);
    chk("rstpri_w8r", q8r, 8'h3C);
    rst = 1'b0;
    #1; chk("rstrel_w1", {7'b0, q1}, 8'h01);
    chk("rstrel_w8", q8, 8'hC3);
    chk("rstrel_w8r", q8r, 8'hC3);

    // reset pulse while closed is ignored
    clk = 1'b0;
    #1; rst = 1'b1;
    #1; chk("rstqual_w1", {7'b0, q1}, 8'h01);
    chk("rstqual_w8r", q8r, 8'hC3);
    rst = 1'b0;
    #1; d8 = 8'h11; clk = 1'b1;
    #1; chk("rstqual_open_w8", q8, 8'h11);
    chk("rstqual_open_w8r", q8r, 8'h11);

    // reset value captured at the falling edge
    rst = 1'b1;
    #1; clk = 1'b0;
    #1; rst = 1'b0;
    #1; chk("rstcap_w8r", q8r, 8'h3C);
    d8 = 8'h77;
    #1; chk("rstcap_dchg_w8r", q8r, 8'h3C);
    chk("rstcap_dchg_w8", q8, 8'h00);

    // glitch: toggle d every 1 ns for 10 ns with the latch open
    clk = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d1 = i[0];
      d8 = 8'(i * 17);
      gexp = 8'(i * 17);
      #1; chk($sformatf("glitch_w1_%0d", i), {7'b0, q1}, {7'b0, i[0]});
      chk($sformatf("glitch_w8_%0d", i), q8, gexp);
    end
    clk = 1'b0;
    #1; d1 = 1'b0; d8 = 8'h00;
    #1; chk("glitch_hold_w1", {7'b0, q1}, 8'h01);
    chk("glitch_hold_w8", q8, 8'h99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
